pe_inject_arbiter: RTL and testbench
====================================

// Module: pe_inject_arbiter
// PURPOSE
//  Shares one switch PE injection port between NUM_REQ local neuron outputs.
//  Neuron outvalid is a 1-cycle pulse with no backpressure, so each requester gets a 1-deep holding slot.
//  A round-robin FSM drains the slots into the switch PE FIFO (i_data_PE / i_wr_valid_PE / o_wr_fifoReady_PE).
//  On the way out it prepends the tile's {x,y} source header to each packet.
// PARAMETERS
//  packet_size  16  full flit width in bits
//  x            1   this tile's X coordinate
//  y            1   this tile's Y coordinate
//  xno_switch   4   switches in X; header field XW = $clog2(xno_switch)
//  yno_switch   4   switches in Y; header field YW = $clog2(yno_switch)
//  NUM_REQ      4   number of requesters (>=2); GW = $clog2(NUM_REQ)
//  Derived: PW = packet_size-XW-YW (payload width)
// PORTS
//  clk              in   1            clock; all logic on the rising edge
//  i_reset          in   1            synchronous, active-high reset
//  i_req_data       in   NUM_REQ*PW   payloads; requester k occupies [k*PW +: PW]
//  i_req_valid      in   NUM_REQ      per-requester 1-cycle valid pulse
//  o_req_ready      out  NUM_REQ      slot k empty (registered; advisory only)
//  o_data_PE        out  packet_size  {x[XW-1:0], y[YW-1:0], payload}; to the switch i_data_PE
//  o_wr_valid_PE    out  1            packet valid; to the switch i_wr_valid_PE
//  i_wr_fifoReady_PE in  1            PE FIFO not full; from the switch o_wr_fifoReady_PE
//  o_grant_id       out  GW           index of the requester currently presented
//  o_overflow       out  NUM_REQ      sticky: a pulse arrived at slot k while it was full
// BEHAVIOUR
//  Reset (sync, i_reset=1 at edge):
//   - every slot empty, o_req_ready all 1s, rr pointer=0, state IDLE;
//   - o_wr_valid_PE=0, o_data_PE=0, o_grant_id=0, o_overflow=0.
//   - Reset mid-SEND discards the in-flight packet and all held slots.
//  Slot k capture (edge): if i_req_valid[k] and (slot empty or slot cleared at this same edge):
//   - slot<=i_req_data[k], full<=1.
//  Overflow (edge): if i_req_valid[k] and slot full and not cleared this edge:
//   - new data is dropped, held data is kept, o_overflow[k]<=1 (cleared only by reset).
//  FSM states IDLE, SEND:
//   IDLE: if any slot full, grant the first full slot searching ptr, ptr+1, ... mod NUM_REQ.
//     - load o_data_PE={x,y,slot[g]}, o_grant_id<=g, o_wr_valid_PE<=1, go to SEND.
//     - else stay in IDLE with o_wr_valid_PE=0.
//   SEND: o_data_PE and o_grant_id held stable.
//     - Transfer when o_wr_valid_PE & i_wr_fifoReady_PE at the edge:
//       slot[g] cleared, ptr<=(g+1) mod NUM_REQ, o_wr_valid_PE<=0, go to IDLE.
//     - If ready=0, wait indefinitely; no timeout and no re-arbitration.
//  Latency: pulse in cycle 0 -> slot full in cycle 1 -> o_wr_valid_PE=1 in cycle 2 (idle port).
//  Throughput: 1 packet per 2 cycles max (mandatory IDLE cycle between grants).
//  Fairness: any full slot is granted within NUM_REQ grants.
//  Header fields are x, y truncated to XW/YW bits; payload is passed unmodified.
//  Input pulses are captured during SEND for any slot, including slot g on its clearing edge.
// TESTING
//  1. Reset, NUM_REQ=4, x=1, y=2, pulse req1 data 0x2A5, ready=1
//     -> o_wr_valid_PE=1 exactly 2 cycles later.
//     -> o_data_PE={2'd1,2'd2,12'h2A5}, o_grant_id=1, one-cycle valid.
//  2. All 4 requesters pulse in the same cycle, ready=1
//     -> packets emitted in order 0,1,2,3, valid every other cycle, o_overflow=0.
//  3. Hold ready=0 while req0 is presented, pulse req0 twice more
//     -> o_data_PE stable, o_overflow[0]=1, first payload kept.
//     -> after ready=1, exactly one packet is sent.
//  4. ptr=2 after grant 1, slots 0 and 3 full
//     -> grant 3 then 0 (round-robin wrap-around).
//  5. Assert i_reset for 1 cycle during SEND with 3 slots full
//     -> next cycle o_wr_valid_PE=0, o_req_ready=4'b1111, o_overflow=0, nothing emitted afterwards.
//  6. Pulse req2 on the edge its slot is transferred
//     -> new data captured, no overflow, sent after the next arbitration.

Source files
------------

// File: rtl/pe_inject_arbiter.sv
// pe_inject_arbiter
// Funnels NUM_REQ single-cycle neuron output pulses into one switch PE
// injection port. Each requester has a one-deep holding slot. A two-state
// round-robin FSM drains the slots and prepends the tile's {x,y} source header.
module pe_inject_arbiter #(
  parameter int packet_size = 16,
  parameter int x           = 1,
  parameter int y           = 1,
  parameter int xno_switch  = 4,
  parameter int yno_switch  = 4,
  parameter int NUM_REQ     = 4,
  localparam int XW = $clog2(xno_switch),
  localparam int YW = $clog2(yno_switch),
  localparam int GW = $clog2(NUM_REQ),
  localparam int PW = packet_size - XW - YW
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ*PW-1:0]     i_req_data,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [packet_size-1:0]    o_data_PE,
  output logic                      o_wr_valid_PE,
  input  logic                      i_wr_fifoReady_PE,
  output logic [GW-1:0]             o_grant_id,
  output logic [NUM_REQ-1:0]        o_overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [XW-1:0] HDR_X = XW'(x);
  localparam logic [YW-1:0] HDR_Y = YW'(y);

  // Returns the first full slot at or after p, wrapping modulo NUM_REQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] full,
                                            input logic [GW-1:0]      p);
    int best_d;
    int d;
    logic [GW-1:0] g;
    best_d = NUM_REQ;
    g      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (full[j]) begin
        d = (j + NUM_REQ - int'(p)) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          g      = GW'(j);
        end
      end
    end
    return g;
  endfunction

  logic [PW-1:0]          slot_data [NUM_REQ];
  logic [NUM_REQ-1:0]     slot_full;
  logic [NUM_REQ-1:0]     slot_clr;
  logic [NUM_REQ-1:0]     slot_cap;
  logic [NUM_REQ-1:0]     overflow;
  logic [0:0]             state;
  logic [GW-1:0]          ptr;
  logic [GW-1:0]          grant_id;
  logic [GW-1:0]          pick;
  logic [GW-1:0]          ptr_next;
  logic                   found;
  logic                   wr_valid;
  logic                   transfer;
  logic [packet_size-1:0] data_pe;

  // Handshake, arbitration choice and per-slot clear/capture strobes.
  always_comb begin
    transfer = (state == SEND) && wr_valid && i_wr_fifoReady_PE;
    found    = |slot_full;
    pick     = rr_pick(slot_full, ptr);
    ptr_next = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    slot_clr = '0;
    slot_cap = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // A slot being drained this edge can accept a new pulse on the same edge.
      slot_clr[k] = transfer && (grant_id == GW'(k));
      slot_cap[k] = i_req_valid[k] && (!slot_full[k] || slot_clr[k]);
    end
  end

  // Slot occupancy and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      slot_full <= '0;
      overflow  <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (slot_cap[k])
          slot_full[k] <= 1'b1;
        else if (slot_clr[k])
          slot_full[k] <= 1'b0;
        if (i_req_valid[k] && slot_full[k] && !slot_clr[k])
          overflow[k] <= 1'b1;
      end
    end
  end

  // Slot payload storage; meaningless while the matching full bit is clear.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (slot_cap[k])
        slot_data[k] <= i_req_data[k*PW +: PW];
    end
  end

  // Round-robin FSM: grant in IDLE, hold the packet in SEND until accepted.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      wr_valid <= 1'b0;
      data_pe  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            data_pe  <= {HDR_X, HDR_Y, slot_data[pick]};
            grant_id <= pick;
            wr_valid <= 1'b1;
            state    <= SEND;
          end
        end
        default: begin
          if (transfer) begin
            ptr      <= ptr_next;
            wr_valid <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_req_ready   = ~slot_full;
  assign o_data_PE     = data_pe;
  assign o_wr_valid_PE = wr_valid;
  assign o_grant_id    = grant_id;
  assign o_overflow    = overflow;

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed bench for pe_inject_arbiter with a packet scoreboard.
module tb_pe_inject_arbiter;

  localparam int PS = 16;
  localparam int NR = 4;
  localparam int PW = 12;
  localparam int GW = 2;
  localparam logic [3:0] HDR = 4'b0110;  // x=1 (2 bits), y=2 (2 bits)

  logic              clk = 1'b0;
  logic              i_reset;
  logic [NR*PW-1:0]  i_req_data;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     o_req_ready;
  logic [PS-1:0]     o_data_PE;
  logic              o_wr_valid_PE;
  logic              i_wr_fifoReady_PE;
  logic [GW-1:0]     o_grant_id;
  logic [NR-1:0]     o_overflow;

  int checks = 0;
  int errors = 0;
  int tx_count = 0;
  logic [GW+PS-1:0] sb [$];

  pe_inject_arbiter #(
    .packet_size(PS), .x(1), .y(2), .xno_switch(4), .yno_switch(4), .NUM_REQ(NR)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_req_data(i_req_data),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .o_data_PE(o_data_PE),
    .o_wr_valid_PE(o_wr_valid_PE),
    .i_wr_fifoReady_PE(i_wr_fifoReady_PE),
    .o_grant_id(o_grant_id),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*PW-1:0] pack(input logic [PW-1:0] d0, input logic [PW-1:0] d1,
                                            input logic [PW-1:0] d2, input logic [PW-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // One-cycle pulse on the requesters in vmask, sampled at the next rising edge.
  task automatic drive(input logic [NR-1:0] vmask, input logic [NR*PW-1:0] d);
    i_req_valid = vmask;
    i_req_data  = d;
    step();
    i_req_valid = '0;
  endtask

  task automatic push(input logic [GW-1:0] g, input logic [PW-1:0] p);
    sb.push_back({g, HDR, p});
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  // Every accepted packet is checked against the head of the scoreboard.
  always @(negedge clk) begin
    logic [GW+PS-1:0] got;
    logic [GW+PS-1:0] exp;
    if (!i_reset && o_wr_valid_PE && i_wr_fifoReady_PE) begin
      tx_count++;
      checks++;
      got = {o_grant_id, o_data_PE};
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      assert (got === exp) else begin
        errors++;
        $error("FAIL packet observed %0h expected %0h", got, exp);
      end
    end
  end

  initial begin
    int tx_before;
    i_reset           = 1'b1;
    i_req_valid       = '0;
    i_req_data        = '0;
    i_wr_fifoReady_PE = 1'b1;
    step();
    step();
    i_reset = 1'b0;

    // Reset state
    chk("rst_valid",    o_wr_valid_PE, 0);
    chk("rst_data",     o_data_PE, 0);
    chk("rst_grant",    o_grant_id, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_ready",    o_req_ready, 4'hF);

    // 1: single request latency and header
    push(2'd1, 12'h2A5);
    drive(4'b0010, pack(0, 12'h2A5, 0, 0));
    chk("t1_slot_full",  o_req_ready, 4'b1101);
    chk("t1_valid_c1",   o_wr_valid_PE, 0);
    step();
    chk("t1_valid_c2",   o_wr_valid_PE, 1);
    chk("t1_data",       o_data_PE, 16'h62A5);
    chk("t1_grant",      o_grant_id, 1);
    step();
    chk("t1_valid_drop", o_wr_valid_PE, 0);
    chk("t1_ready_back", o_req_ready, 4'hF);

    // 2: all four at once, emitted 0..3 on alternate cycles
    do_reset();
    push(2'd0, 12'h100);
    push(2'd1, 12'h211);
    push(2'd2, 12'h322);
    push(2'd3, 12'h433);
    drive(4'b1111, pack(12'h100, 12'h211, 12'h322, 12'h433));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid", o_wr_valid_PE, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) chk("t2_grant", o_grant_id, i / 2);
    end
    chk("t2_overflow", o_overflow, 0);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: backpressure on req0 plus overflow pulses
    i_wr_fifoReady_PE = 1'b0;
    push(2'd0, 12'h5A5);
    drive(4'b0001, pack(12'h5A5, 0, 0, 0));
    step();
    chk("t3_valid", o_wr_valid_PE, 1);
    chk("t3_data",  o_data_PE, 16'h65A5);
    drive(4'b0001, pack(12'h0F0, 0, 0, 0));
    drive(4'b0001, pack(12'h0F1, 0, 0, 0));
    chk("t3_overflow", o_overflow, 4'b0001);
    step();
    step();
    step();
    chk("t3_data_stable",  o_data_PE, 16'h65A5);
    chk("t3_valid_stable", o_wr_valid_PE, 1);
    chk("t3_grant_stable", o_grant_id, 0);
    tx_before = tx_count;
    i_wr_fifoReady_PE = 1'b1;
    step();
    chk("t3_valid_drop", o_wr_valid_PE, 0);
    repeat (4) step();
    chk("t3_one_packet", tx_count - tx_before, 1);
    chk("t3_ovf_sticky", o_overflow, 4'b0001);
    chk("t3_sb_empty",   sb.size(), 0);

    // 4: ptr=2 after grant 1, slots 0 and 3 full -> 3 then 0
    do_reset();
    chk("t4_ovf_cleared", o_overflow, 0);
    i_wr_fifoReady_PE = 1'b0;
    push(2'd1, 12'h111);
    push(2'd3, 12'h3C3);
    push(2'd0, 12'h0C0);
    drive(4'b0010, pack(0, 12'h111, 0, 0));
    step();
    chk("t4_grant1", o_grant_id, 1);
    drive(4'b1001, pack(12'h0C0, 0, 0, 12'h3C3));
    i_wr_fifoReady_PE = 1'b1;
    step();
    step();
    chk("t4_grant3", o_grant_id, 3);
    step();
    step();
    chk("t4_grant0", o_grant_id, 0);
    repeat (4) step();
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_overflow", o_overflow, 0);

    // 5: reset during SEND with three slots full
    i_wr_fifoReady_PE = 1'b0;
    drive(4'b0111, pack(12'hA00, 12'hA11, 12'hA22, 0));
    step();
    chk("t5_in_send", o_wr_valid_PE, 1);
    do_reset();
    chk("t5_valid",    o_wr_valid_PE, 0);
    chk("t5_ready",    o_req_ready, 4'hF);
    chk("t5_overflow", o_overflow, 0);
    chk("t5_data",     o_data_PE, 0);
    tx_before = tx_count;
    i_wr_fifoReady_PE = 1'b1;
    repeat (6) step();
    chk("t5_no_emit", tx_count - tx_before, 0);

    // 6: pulse req2 on the edge its slot drains
    push(2'd2, 12'h2B2);
    drive(4'b0100, pack(0, 0, 12'h2B2, 0));
    step();
    chk("t6_valid", o_wr_valid_PE, 1);
    push(2'd2, 12'h2C2);
    drive(4'b0100, pack(0, 0, 12'h2C2, 0));
    chk("t6_overflow", o_overflow, 0);
    chk("t6_refilled", o_req_ready, 4'b1011);
    chk("t6_idle_gap", o_wr_valid_PE, 0);
    step();
    chk("t6_regrant",  o_grant_id, 2);
    chk("t6_data2",    o_data_PE, 16'h62C2);
    repeat (3) step();
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_ovf_end",  o_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
